// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encoding, FSM states,
// default data path width and the multi-cycle opcode classifier.
package seq_alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_MUL  = 4'b1000,
        OP_DIVU = 4'b1001,
        OP_REMU = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    function automatic logic is_multi(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative one-bit-per-cycle datapath: shift-add multiply and restoring
// unsigned divide sharing one accumulator and two shift registers.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result
);

    // acc: product accumulator / partial remainder
    // x:   multiplicand (shifts left) / dividend shifting out, quotient shifting in
    // y:   multiplier (shifts right) / divisor (held)
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0] rem_try;
    logic [WIDTH:0] rem_diff;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the branches below can leave it unassigned and infer a latch.
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        rem_try  = {acc_q, x_q[WIDTH-1]};
        rem_diff = rem_try - {1'b0, y_q};

        if (load) begin
            acc_d = '0;
            x_d   = a;
            y_d   = b;
            cnt_d = '0;
        end else if (step) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (op == OP_MUL) begin
                if (y_q[0]) begin
                    acc_d = acc_q + x_q;
                end
                x_d = x_q << 1;
                y_d = y_q >> 1;
            end else if (!rem_diff[WIDTH]) begin
                // No borrow: divisor fits, keep the difference and shift in a 1.
                // A zero divisor always lands here, giving all-ones / dividend.
                acc_d = rem_diff[WIDTH-1:0];
                x_d   = {x_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = rem_try[WIDTH-1:0];
                x_d   = {x_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            x_q   <= x_d;
            y_q   <= y_d;
            cnt_q <= cnt_d;
        end
    end

    assign last   = step && (cnt_q == CNT_W'(WIDTH - 1));
    assign result = (op == OP_DIVU) ? x_q : acc_q;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops computed here, iterative
// MUL/DIVU/REMU delegated to seq_alu_muldiv, all sequenced by an IDLE/RUN/DONE FSM.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUCtrl,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             zero
);

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic             md_load;
    logic             md_step;
    logic             md_last;
    logic [WIDTH-1:0] md_result;
    logic [WIDTH-1:0] final_result;

    assign accept  = (state_q == S_IDLE) && start;
    assign md_load = accept && is_multi(ALUCtrl);
    assign md_step = (state_q == S_RUN);

    seq_alu_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .load   (md_load),
        .step   (md_step),
        .op     (op_q),
        .a      (inA),
        .b      (inB),
        .last   (md_last),
        .result (md_result)
    );

    always_comb begin
        final_result = '0;
        case (op_q)
            OP_AND:  final_result = a_q & b_q;
            OP_OR:   final_result = a_q | b_q;
            OP_ADD:  final_result = a_q + b_q;
            OP_SUB:  final_result = a_q - b_q;
            OP_SLT:  final_result = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_MUL, OP_DIVU, OP_REMU: final_result = md_result;
            default: final_result = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        done_d   = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        // busy trails RUN by one edge, so it covers exactly the WIDTH iteration cycles.
        busy_d   = (state_q == S_RUN);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = ALUCtrl;
                    a_d     = inA;
                    b_d     = inB;
                    state_d = is_multi(ALUCtrl) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (md_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                result_d = final_result;
                zero_d   = (final_result == '0);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ALUResult = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus randomized
// operations checked against an arithmetic reference model.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 32;
    localparam int MAX_WAIT = 100;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   ALUCtrl;
    logic [W-1:0] inA;
    logic [W-1:0] inB;
    logic         busy;
    logic         done;
    logic [W-1:0] ALUResult;
    logic         zero;

    int n_vec = 0;
    int n_err = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ALUCtrl   (ALUCtrl),
        .inA       (inA),
        .inB       (inB),
        .busy      (busy),
        .done      (done),
        .ALUResult (ALUResult),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model straight from the operation definitions.
    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 1 : 0;
            4'b1000: begin p = 64'(a) * 64'(b); return p[W-1:0]; end
            4'b1001: return (b == 0) ? '1 : a / b;
            4'b1010: return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic bit multi_op(input logic [3:0] op);
        return op == 4'b1000 || op == 4'b1001 || op == 4'b1010;
    endfunction

    // Issue one operation; optionally pulse a competing start at cycle glitch_at.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int glitch_at,
                          output logic [W-1:0] res, output logic z,
                          output int latency, output int busy_cycles, output bit seen);
        int both = 0;
        latency = 0;
        busy_cycles = 0;
        seen = 0;
        @(negedge clk);
        start = 1'b1; ALUCtrl = op; inA = a; inB = b;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= MAX_WAIT; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (busy && done) both++;
            if (busy) busy_cycles++;
            if (done) begin
                latency = n; seen = 1; res = ALUResult; z = zero;
                break;
            end
            if (n == glitch_at) begin
                start = 1'b1; ALUCtrl = 4'b0010; inA = $urandom; inB = $urandom;
            end
        end
        check("busy_and_done_overlap", 64'(both), 64'd0);
        @(posedge clk); #1;
        check("done_one_pulse", 64'(done), 64'd0);
        if (seen) check("result_held", 64'(ALUResult), 64'(res));
    endtask

    task automatic check_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int glitch_at);
        logic [W-1:0] res, exp;
        logic z;
        int lat, bc;
        bit seen;
        res = '0; z = 1'b0;
        exp = model(op, a, b);
        run_op(op, a, b, glitch_at, res, z, lat, bc, seen);
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        check({tag, " result"}, 64'(res), 64'(exp));
        check({tag, " zero"}, 64'(z), 64'(exp == 0));
        check({tag, " latency"}, 64'(lat), multi_op(op) ? 64'(W + 1) : 64'd1);
        check({tag, " busy_cycles"}, 64'(bc), multi_op(op) ? 64'(W) : 64'd0);
    endtask

    initial begin
        int saw_done;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic [3:0]   defined_ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                          4'b0111, 4'b1000, 4'b1001, 4'b1010};

        reset = 1'b1; start = 1'b0; ALUCtrl = '0; inA = '0; inB = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", 64'(ALUResult), 64'd0);
        check("reset zero", 64'(zero), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        check_op("add_5_7", 4'b0010, 32'd5, 32'd7, -1);
        check_op("sub_eq", 4'b0110, 32'h9, 32'h9, -1);
        check_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'd1, -1);
        check_op("slt_pos", 4'b0111, 32'd1, 32'hFFFF_FFFF, -1);
        check_op("mul_ffff", 4'b1000, 32'h0000_FFFF, 32'h0001_0001, -1);
        check_op("divu_100_7", 4'b1001, 32'd100, 32'd7, -1);
        check_op("remu_100_7", 4'b1010, 32'd100, 32'd7, -1);
        check_op("divu_by0", 4'b1001, 32'd5, 32'd0, -1);
        check_op("remu_by0", 4'b1010, 32'd5, 32'd0, -1);
        check_op("undef_op", 4'b1111, 32'h1234, 32'h5678, -1);
        check_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, -1);
        check_op("mul_ignore_start", 4'b1000, 32'h0012_3456, 32'h0000_0789, 10);

        // Reset aborts a DIVU in flight at cycle 15.
        @(negedge clk);
        start = 1'b1; ALUCtrl = 4'b1001; inA = 32'd1000; inB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort result", 64'(ALUResult), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) saw_done++;
        end
        check("abort no_done", 64'(saw_done), 64'd0);
        check_op("add_after_abort", 4'b0010, 32'd20, 32'd22, -1);

        for (int v = 0; v < 30; v++) begin
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : defined_ops[$urandom_range(0, 7)];
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = '0;
                1: b = W'($urandom_range(1, 20));
                2: b = a;
                default: b = $urandom;
            endcase
            check_op($sformatf("rand%0d_op%0h", v, op), op, a, b, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
